// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit for a single-cycle core. It holds a loadable
// on-chip instruction memory, owns the program counter, and presents one
// instruction per clock to the core.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   load_start    in   in IDLE/HALT: begin loading at word 0
//   load_valid    in   load_data carries a word to store
//   load_data     in   instruction word to store (32)
//   load_last     in   final word of the load (qualified by load_valid)
//   load_ready    out  high only while loading
//   run_start     in   in IDLE/HALT: start execution at RESET_PC
//   branch_taken  in   core's branch decision for the current instr
//   instr         out  instruction to the core (NOP outside RUN)
//   pc            out  address of instr
//   instr_valid   out  high only while running
//   halted        out  high in HALT
//   fault         out  sticky error flag
module instr_fetch #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   input  logic        run_start,
   input  logic        branch_taken,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   output logic        halted,
   output logic        fault
);

   localparam int          AW       = $clog2(IMEM_DEPTH);
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] ECALL    = 32'h0000_0073;
   localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_HALT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_pc;
   logic [31:0]     w_pc_nxt;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   w_wptr_nxt;
   logic            r_fault;
   logic            w_fault_nxt;

   // Memory has no reset: contents survive rst and partial reloads.
   logic [31:0]     r_imem [IMEM_DEPTH];

   logic [31:0]     w_fetch;
   logic [31:0]     w_bimm;
   logic [31:0]     w_pc_seq;
   logic            w_pc_bad;
   logic            w_wr_en;
   logic            w_wptr_last;

   // Zero-latency fetch: combinational read at the registered pc.
   assign w_fetch = r_imem[r_pc[AW+1:2]];

   // B-type immediate, sign-extended from bit 12.
   assign w_bimm = {{19{w_fetch[31]}}, w_fetch[31], w_fetch[7],
                    w_fetch[30:25], w_fetch[11:8], 1'b0};

   // Adder wraps modulo 2^32, so a backward branch past 0 lands far above
   // PC_LIMIT and is caught by the range check.
   assign w_pc_seq = branch_taken ? (r_pc + w_bimm) : (r_pc + 32'd4);
   assign w_pc_bad = (w_pc_seq[1:0] != 2'b00) || (w_pc_seq >= PC_LIMIT);

   assign w_wptr_last = (r_wptr == AW'(IMEM_DEPTH - 1));
   // A write coinciding with rst is dropped along with the load.
   assign w_wr_en     = (r_state == S_LOAD) && load_valid && !rst;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_wptr_nxt  = r_wptr;
      w_fault_nxt = r_fault;
      case (r_state)
         S_IDLE, S_HALT: begin
            // Load takes priority when both starts arrive together.
            if (load_start) begin
               w_state_nxt = S_LOAD;
               w_wptr_nxt  = '0;
               w_fault_nxt = 1'b0;
            end else if (run_start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = RESET_PC;
               w_fault_nxt = 1'b0;
            end
         end
         S_LOAD: begin
            if (load_valid) begin
               w_wptr_nxt = r_wptr + 1'b1;
               if (load_last || w_wptr_last) begin
                  w_state_nxt = S_IDLE;
               end
               // Memory filled without the sender marking the end.
               if (w_wptr_last && !load_last) begin
                  w_fault_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            // On ECALL or a bad target the pc stays on the terminating
            // instruction so the core can report where it stopped.
            if (w_fetch == ECALL) begin
               w_state_nxt = S_HALT;
            end else if (w_pc_bad) begin
               w_state_nxt = S_HALT;
               w_fault_nxt = 1'b1;
            end else begin
               w_pc_nxt = w_pc_seq;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_wptr  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_wptr  <= w_wptr_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_imem[r_wptr] <= load_data;
      end
   end

   assign instr       = (r_state == S_RUN) ? w_fetch : NOP;
   assign pc          = r_pc;
   assign instr_valid = (r_state == S_RUN);
   assign halted      = (r_state == S_HALT);
   assign load_ready  = (r_state == S_LOAD);
   assign fault       = r_fault;

endmodule
